// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: ALUOp encodings, control-bundle layout and the
// ID/EX register image with its bubble value.
package pipe_pkg;

    localparam int CTRL_W = 10;

    // Control bundle bit positions, MSB first: {reg_write, mem_read, mem_write,
    // mem_to_reg[1:0], alu_src1, alu_src2, reg_dst[1:0], branch}
    localparam int CTRL_REG_WRITE  = 9;
    localparam int CTRL_MEM_READ   = 8;
    localparam int CTRL_MEM_WRITE  = 7;
    localparam int CTRL_MEM2REG_HI = 6;
    localparam int CTRL_MEM2REG_LO = 5;
    localparam int CTRL_ALU_SRC1   = 4;
    localparam int CTRL_ALU_SRC2   = 3;
    localparam int CTRL_REG_DST_HI = 2;
    localparam int CTRL_REG_DST_LO = 1;
    localparam int CTRL_BRANCH     = 0;

    localparam int         ALU_OP_W         = 4;
    localparam int         ALU_UNSIGNED_BIT = 3;
    localparam logic [2:0] ALU_ADD          = 3'b000;
    localparam logic [2:0] ALU_SUB          = 3'b001;
    localparam logic [2:0] ALU_RTYPE        = 3'b010;
    localparam logic [2:0] ALU_AND          = 3'b100;
    localparam logic [2:0] ALU_SLT          = 3'b101;

    localparam logic [15:0] BUBBLE_CNT_MAX = 16'hFFFF;

    typedef struct packed {
        logic                valid;
        logic [ALU_OP_W-1:0] alu_op;
        logic [5:0]          funct;
        logic [4:0]          shamt;
        logic [31:0]         rs_data;
        logic [31:0]         rt_data;
        logic [31:0]         imm_ext;
        logic [31:0]         pc_plus4;
        logic [4:0]          rs;
        logic [4:0]          rt;
        logic [4:0]          rd;
        logic [CTRL_W-1:0]   ctrl;
    } id_ex_t;

    // All-zero image: invalid, no control effects, ALUOp = signed ADD.
    localparam id_ex_t ID_EX_BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check between the load in EX and the
// instruction currently in ID.
module load_use_detect
    import pipe_pkg::*;
(
    input  logic       id_valid,
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       flush,
    output logic       hazard
);

    logic rt_match;

    // A load into $zero never produces a value worth waiting for.
    assign rt_match = (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    assign hazard   = id_valid && ex_valid && ex_mem_read && rt_match && !flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and a saturating
// count of inserted bubbles.
module id_ex_stage
    import pipe_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    input  logic [ALU_OP_W-1:0] id_alu_op,
    input  logic [5:0]          id_funct,
    input  logic [4:0]          id_shamt,
    input  logic [31:0]         id_rs_data,
    input  logic [31:0]         id_rt_data,
    input  logic [31:0]         id_imm_ext,
    input  logic [31:0]         id_pc_plus4,
    input  logic [4:0]          id_rs,
    input  logic [4:0]          id_rt,
    input  logic [4:0]          id_rd,
    input  logic [CTRL_W-1:0]   id_ctrl,
    input  logic                flush,
    input  logic                stall_ex,
    output logic                ex_valid,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic [5:0]          ex_funct,
    output logic [4:0]          ex_shamt,
    output logic [31:0]         ex_rs_data,
    output logic [31:0]         ex_rt_data,
    output logic [31:0]         ex_imm_ext,
    output logic [31:0]         ex_pc_plus4,
    output logic [4:0]          ex_rs,
    output logic [4:0]          ex_rt,
    output logic [4:0]          ex_rd,
    output logic [CTRL_W-1:0]   ex_ctrl,
    output logic                hazard_stall,
    output logic [15:0]         bubble_cnt
);

    id_ex_t      ex_q, ex_d;
    logic [15:0] bubble_cnt_q, bubble_cnt_d;

    load_use_detect u_load_use_detect (
        .id_valid    (id_valid),
        .ex_valid    (ex_q.valid),
        .ex_mem_read (ex_q.ctrl[CTRL_MEM_READ]),
        .ex_rt       (ex_q.rt),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .flush       (flush),
        .hazard      (hazard_stall)
    );

    always_comb begin
        ex_d         = ex_q;
        bubble_cnt_d = bubble_cnt_q;
        if (flush) begin
            ex_d = ID_EX_BUBBLE;
        end else if (stall_ex) begin
            ex_d = ex_q;
        end else if (hazard_stall) begin
            ex_d = ID_EX_BUBBLE;
            if (bubble_cnt_q != BUBBLE_CNT_MAX)
                bubble_cnt_d = bubble_cnt_q + 16'd1;
        end else if (id_valid) begin
            ex_d.valid    = 1'b1;
            ex_d.alu_op   = id_alu_op;
            ex_d.funct    = id_funct;
            ex_d.shamt    = id_shamt;
            ex_d.rs_data  = id_rs_data;
            ex_d.rt_data  = id_rt_data;
            ex_d.imm_ext  = id_imm_ext;
            ex_d.pc_plus4 = id_pc_plus4;
            ex_d.rs       = id_rs;
            ex_d.rt       = id_rt;
            ex_d.rd       = id_rd;
            ex_d.ctrl     = id_ctrl;
        end else begin
            ex_d = ID_EX_BUBBLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q         <= ID_EX_BUBBLE;
            bubble_cnt_q <= 16'd0;
        end else begin
            ex_q         <= ex_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign ex_valid    = ex_q.valid;
    assign ex_alu_op   = ex_q.alu_op;
    assign ex_funct    = ex_q.funct;
    assign ex_shamt    = ex_q.shamt;
    assign ex_rs_data  = ex_q.rs_data;
    assign ex_rt_data  = ex_q.rt_data;
    assign ex_imm_ext  = ex_q.imm_ext;
    assign ex_pc_plus4 = ex_q.pc_plus4;
    assign ex_rs       = ex_q.rs;
    assign ex_rt       = ex_q.rt;
    assign ex_rd       = ex_q.rd;
    assign ex_ctrl     = ex_q.ctrl;
    assign bubble_cnt  = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, hand-written
// hold/saturation/reset sequences and a randomized run against a reference model.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset, id_valid, flush, stall_ex;
    logic [3:0]  id_alu_op;
    logic [5:0]  id_funct;
    logic [4:0]  id_shamt, id_rs, id_rt, id_rd;
    logic [31:0] id_rs_data, id_rt_data, id_imm_ext, id_pc_plus4;
    logic [9:0]  id_ctrl;
    logic        ex_valid, hazard_stall;
    logic [3:0]  ex_alu_op;
    logic [5:0]  ex_funct;
    logic [4:0]  ex_shamt, ex_rs, ex_rt, ex_rd;
    logic [31:0] ex_rs_data, ex_rt_data, ex_imm_ext, ex_pc_plus4;
    logic [9:0]  ex_ctrl;
    logic [15:0] bubble_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_alu_op(id_alu_op),
        .id_funct(id_funct), .id_shamt(id_shamt), .id_rs_data(id_rs_data),
        .id_rt_data(id_rt_data), .id_imm_ext(id_imm_ext), .id_pc_plus4(id_pc_plus4),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_ctrl(id_ctrl),
        .flush(flush), .stall_ex(stall_ex), .ex_valid(ex_valid), .ex_alu_op(ex_alu_op),
        .ex_funct(ex_funct), .ex_shamt(ex_shamt), .ex_rs_data(ex_rs_data),
        .ex_rt_data(ex_rt_data), .ex_imm_ext(ex_imm_ext), .ex_pc_plus4(ex_pc_plus4),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
        .hazard_stall(hazard_stall), .bubble_cnt(bubble_cnt)
    );

    // reg_write=bit9, mem_read=bit8, mem_to_reg=bits6:5
    localparam logic [9:0] C_RTYPE = 10'b10_0000_0010;
    localparam logic [9:0] C_LW    = 10'b11_0010_1000;

    typedef struct packed {
        logic        valid;
        logic [3:0]  alu_op;
        logic [5:0]  funct;
        logic [4:0]  shamt;
        logic [31:0] rs_data, rt_data, imm, pc4;
        logic [4:0]  rs, rt, rd;
        logic [9:0]  ctrl;
    } ex_img_t;

    ex_img_t m_ex;
    int      m_cnt;

    function automatic ex_img_t dut_img();
        return '{ex_valid, ex_alu_op, ex_funct, ex_shamt, ex_rs_data, ex_rt_data,
                 ex_imm_ext, ex_pc_plus4, ex_rs, ex_rt, ex_rd, ex_ctrl};
    endfunction

    function automatic logic model_hazard();
        return id_valid && m_ex.valid && m_ex.ctrl[8] && (m_ex.rt != 0) &&
               ((m_ex.rt == id_rs) || (m_ex.rt == id_rt)) && !flush;
    endfunction

    // Priority: reset, flush, stall, load-use bubble, normal load.
    task automatic model_edge();
        logic hz;
        hz = model_hazard();
        if (reset) begin
            m_ex = '0; m_cnt = 0;
        end else if (flush) begin
            m_ex = '0;
        end else if (stall_ex) begin
            // hold
        end else if (hz) begin
            m_ex = '0;
            m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
        end else if (id_valid) begin
            m_ex = '{1'b1, id_alu_op, id_funct, id_shamt, id_rs_data, id_rt_data,
                     id_imm_ext, id_pc_plus4, id_rs, id_rt, id_rd, id_ctrl};
        end else begin
            m_ex = '0;
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_img(input string name, input ex_img_t exp);
        checks++;
        if (dut_img() !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, dut_img(), exp);
        end
    endtask

    // Inputs already driven after a negedge: check combinational hazard,
    // advance one edge, check registered outputs against the model.
    task automatic model_cycle(input string name);
        #1;
        check({name, ".hazard"}, 64'(hazard_stall), 64'(model_hazard()));
        @(posedge clk);
        model_edge();
        #1;
        check_img({name, ".ex"}, m_ex);
        check({name, ".cnt"}, 64'(bubble_cnt), 64'(m_cnt));
        @(negedge clk);
    endtask

    task automatic set_id(input logic v, input logic [3:0] op, input logic [5:0] fn,
                          input logic [31:0] rsd, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [9:0] ctrl);
        id_valid = v; id_alu_op = op; id_funct = fn; id_rs_data = rsd;
        id_rs = rs; id_rt = rt; id_ctrl = ctrl;
        id_shamt = 5'd3; id_rt_data = 32'd7; id_imm_ext = 32'hFFFF_FFF0;
        id_pc_plus4 = 32'h0000_1004; id_rd = 5'd3;
    endtask

    typedef struct {
        string      name;
        logic       rst, v, fl, st;
        logic [3:0] op;
        logic [5:0] fn;
        logic [31:0] rsd;
        logic [4:0] rs, rt;
        logic [9:0] ctrl;
        logic       chk_hz, e_hz, e_v;
        logic [3:0] e_op;
        logic [5:0] e_fn;
        logic [31:0] e_rsd;
        logic [9:0] e_ctrl;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vt[$];

    initial begin
        reset = 1; flush = 0; stall_ex = 0;
        set_id(0, 0, 0, 0, 0, 0, 0);
        //         name       rst v fl st op     fn     rsd  rs rt ctrl     chk hz v op     fn     rsd  ctrl     cnt
        vt.push_back('{"reset",   1,0,0,0, 4'h0, 6'h00, 0,   0, 0, 10'h0,   0,0, 0,4'h0, 6'h00, 0,   10'h0,   0});
        vt.push_back('{"rtype",   0,1,0,0, 4'h2, 6'h20, 5,   1, 2, C_RTYPE, 1,0, 1,4'h2, 6'h20, 5,   C_RTYPE, 0});
        vt.push_back('{"lw",      0,1,0,0, 4'h0, 6'h00, 100, 9, 8, C_LW,    1,0, 1,4'h0, 6'h00, 100, C_LW,    0});
        vt.push_back('{"loaduse", 0,1,0,0, 4'h2, 6'h22, 55,  8, 3, C_RTYPE, 1,1, 0,4'h0, 6'h00, 0,   10'h0,   1});
        vt.push_back('{"retry",   0,1,0,0, 4'h2, 6'h22, 55,  8, 3, C_RTYPE, 1,0, 1,4'h2, 6'h22, 55,  C_RTYPE, 1});
        vt.push_back('{"lw_zero", 0,1,0,0, 4'hA, 6'h00, 9,   4, 0, C_LW,    1,0, 1,4'hA, 6'h00, 9,   C_LW,    1});
        vt.push_back('{"zero_ex", 0,1,0,0, 4'h2, 6'h25, 11,  0, 0, C_RTYPE, 1,0, 1,4'h2, 6'h25, 11,  C_RTYPE, 1});
        vt.push_back('{"lw2",     0,1,0,0, 4'h0, 6'h00, 3,   9, 8, C_LW,    1,0, 1,4'h0, 6'h00, 3,   C_LW,    1});
        vt.push_back('{"fl_st",   0,1,1,1, 4'h2, 6'h20, 77,  8, 8, C_RTYPE, 1,0, 0,4'h0, 6'h00, 0,   10'h0,   1});
        vt.push_back('{"idle",    0,0,0,0, 4'h2, 6'h20, 77,  8, 8, C_RTYPE, 1,0, 0,4'h0, 6'h00, 0,   10'h0,   1});

        @(negedge clk);
        foreach (vt[i]) begin
            reset = vt[i].rst; flush = vt[i].fl; stall_ex = vt[i].st;
            set_id(vt[i].v, vt[i].op, vt[i].fn, vt[i].rsd, vt[i].rs, vt[i].rt, vt[i].ctrl);
            #1;
            if (vt[i].chk_hz) check({vt[i].name, ".hazard"}, 64'(hazard_stall), 64'(vt[i].e_hz));
            @(posedge clk); #1;
            check({vt[i].name, ".valid"}, 64'(ex_valid), 64'(vt[i].e_v));
            check({vt[i].name, ".alu_op"}, 64'(ex_alu_op), 64'(vt[i].e_op));
            check({vt[i].name, ".funct"}, 64'(ex_funct), 64'(vt[i].e_fn));
            check({vt[i].name, ".rs_data"}, 64'(ex_rs_data), 64'(vt[i].e_rsd));
            check({vt[i].name, ".ctrl"}, 64'(ex_ctrl), 64'(vt[i].e_ctrl));
            check({vt[i].name, ".cnt"}, 64'(bubble_cnt), 64'(vt[i].e_cnt));
            @(negedge clk);
        end

        // Hold: stall for three cycles with changing ID inputs.
        reset = 1; model_cycle("hold_rst");
        reset = 0;
        set_id(1, 4'h2, 6'h2A, 32'hCAFE_0001, 5'd4, 5'd5, C_RTYPE);
        model_cycle("hold_load");
        for (int k = 0; k < 3; k++) begin
            stall_ex = 1;
            set_id(1, 4'(k), 6'(k + 1), 32'(k * 11), 5'(k), 5'(k + 6), C_LW);
            model_cycle("hold");
            check("hold.rs_data", 64'(ex_rs_data), 64'h0000_0000_CAFE_0001);
        end
        stall_ex = 0;

        // Saturation: backdoor the counter near the top, then two load-use hazards.
        set_id(1, 4'h0, 6'h00, 32'd1, 5'd9, 5'd8, C_LW);
        model_cycle("sat_lw");
        force dut.bubble_cnt_q = 16'hFFFE;
        #1;
        release dut.bubble_cnt_q;
        m_cnt = 16'hFFFE;
        set_id(1, 4'h2, 6'h20, 32'd2, 5'd8, 5'd1, C_RTYPE);
        model_cycle("sat_hz1");
        check("sat.cnt_ffff", 64'(bubble_cnt), 64'hFFFF);
        set_id(1, 4'h0, 6'h00, 32'd1, 5'd9, 5'd8, C_LW);
        model_cycle("sat_lw2");
        set_id(1, 4'h2, 6'h20, 32'd2, 5'd1, 5'd8, C_RTYPE);
        model_cycle("sat_hz2");
        check("sat.cnt_stays", 64'(bubble_cnt), 64'hFFFF);

        // Reset wins over a stall and over a pending hazard.
        set_id(1, 4'h0, 6'h00, 32'd1, 5'd9, 5'd8, C_LW);
        model_cycle("rst_lw");
        reset = 1; stall_ex = 1;
        set_id(1, 4'h2, 6'h20, 32'd2, 5'd8, 5'd8, C_RTYPE);
        model_cycle("rst_stall");
        check("rst.cnt_zero", 64'(bubble_cnt), 64'h0);
        check("rst.valid_zero", 64'(ex_valid), 64'h0);
        reset = 0; stall_ex = 0;
        #1;
        check("rst.hazard_zero", 64'(hazard_stall), 64'h0);

        // Randomized run against the model.
        for (int n = 0; n < 3000; n++) begin
            reset    = ($urandom_range(99) == 0);
            flush    = ($urandom_range(7) == 0);
            stall_ex = ($urandom_range(5) == 0);
            id_valid = ($urandom_range(3) != 0);
            id_alu_op = 4'($urandom); id_funct = 6'($urandom); id_shamt = 5'($urandom);
            id_rs_data = $urandom; id_rt_data = $urandom; id_imm_ext = $urandom;
            id_pc_plus4 = $urandom;
            id_rs = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom_range(8, 10));
            id_rt = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom_range(8, 10));
            id_rd = 5'($urandom);
            id_ctrl = 10'($urandom);
            model_cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high; sampled on clk rising edge only.
REQ-003 id_valid  input  1  ID stage holds a real instruction.
REQ-004 id_alu_op  input  4  ALUOp for the ALU control stage; bit3=unsigned, [2:0]: 000 ADD, 001 SUB, 010 R-type (use funct), 100 AND, 101 SLT.
REQ-005 id_funct  input  6  instruction funct; id_shamt  input  5  shift amount.
REQ-006 id_rs_data, id_rt_data, id_imm_ext, id_pc_plus4  input  32 each  operands, sign/zero-extended immediate, PC+4.
REQ-007 id_rs, id_rt, id_rd  input  5 each  register specifiers.
REQ-008 id_ctrl  input  10  control bundle {reg_write, mem_read, mem_write, mem_to_reg[1:0], alu_src1, alu_src2, reg_dst[1:0], branch}; field positions per package.
REQ-009 flush  input  1  kill the instruction entering EX (taken branch/jump).
REQ-010 stall_ex  input  1  downstream hold; EX register keeps its contents.
REQ-011 ex_valid, ex_alu_op, ex_funct, ex_shamt, ex_rs_data, ex_rt_data, ex_imm_ext, ex_pc_plus4, ex_rs, ex_rt, ex_rd, ex_ctrl  output  widths as ID counterparts  registered EX-stage copies.
REQ-012 hazard_stall  output  1  combinational; hold PC and IF/ID this cycle.
REQ-013 bubble_cnt  output  16  count of bubbles inserted by load-use stalls.

Function
REQ-014 Latency SHALL be exactly one clk cycle from ID inputs to ex_* outputs.
REQ-015 hazard_stall SHALL equal id_valid & ex_valid & ex_ctrl.mem_read & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt) & ~flush.
REQ-016 Edge update priority SHALL be: reset > flush > stall_ex > hazard_stall > id_valid load.
REQ-017 flush=1: register SHALL load a bubble regardless of stall_ex or hazard_stall.
REQ-018 stall_ex=1 (no flush): all ex_* SHALL hold previous values; bubble_cnt SHALL not change.
REQ-019 hazard_stall=1 (no flush, no stall_ex): register SHALL load a bubble and bubble_cnt SHALL increment by 1.
REQ-020 Otherwise: id_valid=1 loads all ID fields with ex_valid=1; id_valid=0 loads a bubble.
REQ-021 Bubble SHALL be: ex_valid=0, ex_ctrl=0, ex_alu_op=4'b0000 (signed ADD), ex_funct=0, ex_shamt=0, all data/specifier fields 0.
REQ-022 bubble_cnt SHALL saturate at 16'hFFFF (no wrap).
REQ-023 ex_alu_op and ex_funct SHALL be passed unmodified; no decoding here.

Reset
REQ-024 On reset, all ex_* SHALL take the bubble value and bubble_cnt SHALL be 0.
REQ-025 Reset asserted mid-stall SHALL win; hazard_stall SHALL read 0 the cycle after reset (ex_valid=0).

Structure
REQ-026 Shared package pipe_pkg SHALL hold ALUOp encodings, ctrl bundle field indices/width, and the bubble constant.
REQ-027 Load-use comparison SHALL live in sub-module load_use_detect (combinational); the register and counter stay in id_ex_stage.

Verification
REQ-028 Normal flow: id_valid=1, id_alu_op=4'b0010, id_funct=6'h20, rs_data=5, rt_data=7 -> next cycle ex_valid=1, ex_alu_op=4'b0010, ex_funct=6'h20, ex_rs_data=5.
REQ-029 Load-use: EX holds lw with ex_rt=8, ID has id_rs=8 -> hazard_stall=1 same cycle; next cycle ex_valid=0, ex_ctrl=0, bubble_cnt=1; following cycle ID instruction enters EX.
REQ-030 $zero exemption: EX lw ex_rt=0, id_rs=0 -> hazard_stall=0, no bubble.
REQ-031 Flush+stall: flush=1, stall_ex=1, hazard condition true -> hazard_stall=0, next cycle bubble, bubble_cnt unchanged.
REQ-032 Hold: stall_ex=1 for 3 cycles with changing ID inputs -> ex_* constant for all 3 cycles.
REQ-033 Saturation/reset: preload bubble_cnt to 16'hFFFE, two hazards -> 16'hFFFF then stays; assert reset -> bubble_cnt=0, ex_valid=0 next edge.
